updown_counter: RTL

Parametrised successor to the team's 4-bit enable counter. Adds configurable width and modulus, up/down direction, synchronous load and clear, and a choice of wrap or saturate at the count limits. It also provides a one-cycle terminal-event pulse and a sticky overflow flag. It is a drop-in building block for timers, dividers and event counters; with default parameters and `up_down` tied high it matches the original 4-bit counter's count sequence.

---
 rtl/updown_counter.sv | 77 +++++++
 1 files changed

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - parametrised up/down counter with load, clear, wrap/saturate,
// terminal-event pulse and sticky overflow flag.
module updown_counter #(
    parameter int unsigned          WIDTH     = 4,
    parameter logic [WIDTH-1:0]     MAX_COUNT = {WIDTH{1'b1}},
    parameter bit                   SATURATE  = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    output logic [WIDTH-1:0] counter_out,
    output logic             terminal,
    output logic             overflow
);

    localparam logic [WIDTH-1:0] L_ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;
    logic             r_terminal;
    logic             r_overflow;

    logic [WIDTH-1:0] w_next_count;
    logic             w_next_terminal;
    logic             w_next_overflow;
    logic [WIDTH-1:0] w_load_clamped;
    logic             w_at_limit;
    logic [WIDTH-1:0] w_wrap_value;
    logic [WIDTH-1:0] w_step_value;

    assign w_load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;

    // The limit being approached, the value taken on wrapping past it, and the ordinary step.
    assign w_at_limit   = up_down ? (r_count == MAX_COUNT) : (r_count == '0);
    assign w_wrap_value = up_down ? '0 : MAX_COUNT;
    assign w_step_value = up_down ? (r_count + L_ONE) : (r_count - L_ONE);

    always_comb begin
        w_next_count    = r_count;
        w_next_terminal = 1'b0;
        w_next_overflow = r_overflow;
        if (clear) begin
            w_next_count    = '0;
            w_next_overflow = 1'b0;
        end else if (load) begin
            w_next_count = w_load_clamped;
        end else if (enable) begin
            if (w_at_limit) begin
                w_next_terminal = 1'b1;
                w_next_overflow = 1'b1;
                w_next_count    = SATURATE ? r_count : w_wrap_value;
            end else begin
                w_next_count = w_step_value;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count    <= '0;
            r_terminal <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_terminal <= w_next_terminal;
            r_overflow <= w_next_overflow;
        end
    end

    assign counter_out = r_count;
    assign terminal    = r_terminal;
    assign overflow    = r_overflow;

endmodule
